// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if -- bundle of every non-clock signal of alu_arbiter.
//
// Groups:
//    req0_* / req1_* : requester handshakes (valid/ready) plus cmd, operands, s
//    alu_*           : operands/command/carry towards an external combinational
//                      ALU, and its result/flags {Z,C,N,V} coming back
//    rsp_*           : registered response held until the consumer takes it
//    status, busy    : architectural flag register {Z,C,N,V}, FSM-not-idle
//
// Modports:
//    slave  : the arbiter side
//    master : the environment side (requesters, ALU, response consumer)
//
// WORD_WIDTH defaults to `WORD_WIDTH (32 unless settings.h provides another value).

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface alu_arbiter_if #(
   parameter int unsigned WORD_WIDTH = `WORD_WIDTH
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [3:0]            req0_cmd;
   logic [WORD_WIDTH-1:0] req0_val1;
   logic [WORD_WIDTH-1:0] req0_val2;
   logic                  req0_s;

   logic                  req1_valid;
   logic                  req1_ready;
   logic [3:0]            req1_cmd;
   logic [WORD_WIDTH-1:0] req1_val1;
   logic [WORD_WIDTH-1:0] req1_val2;
   logic                  req1_s;

   logic [WORD_WIDTH-1:0] alu_val1;
   logic [WORD_WIDTH-1:0] alu_val2;
   logic                  alu_carry;
   logic [3:0]            alu_cmd;
   logic [WORD_WIDTH-1:0] alu_res;
   logic [3:0]            alu_sr;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_id;
   logic [WORD_WIDTH-1:0] rsp_res;
   logic [3:0]            rsp_sr;

   logic [3:0]            status;
   logic                  busy;

   modport slave (
      input  req0_valid, req0_cmd, req0_val1, req0_val2, req0_s,
      output req0_ready,
      input  req1_valid, req1_cmd, req1_val1, req1_val2, req1_s,
      output req1_ready,
      output alu_val1, alu_val2, alu_carry, alu_cmd,
      input  alu_res, alu_sr,
      output rsp_valid, rsp_id, rsp_res, rsp_sr,
      input  rsp_ready,
      output status, busy
   );

   modport master (
      output req0_valid, req0_cmd, req0_val1, req0_val2, req0_s,
      input  req0_ready,
      output req1_valid, req1_cmd, req1_val1, req1_val2, req1_s,
      input  req1_ready,
      input  alu_val1, alu_val2, alu_carry, alu_cmd,
      output alu_res, alu_sr,
      input  rsp_valid, rsp_id, rsp_res, rsp_sr,
      output rsp_ready,
      input  status, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter -- shares one external combinational ALU between two requesters.
//
// A request is granted in IDLE (ready asserted combinationally that cycle) and
// its operation latched; ISSUE captures the ALU result/flags into the response
// register (and into status when s=1); HOLD keeps the response until rsp_ready.
// Grant-to-response latency is 2 cycles, back-to-back interval 3 cycles.
//
// Ports:
//    clk : system clock, all state changes on its rising edge
//    rst : synchronous active-high reset
//    bus : alu_arbiter_if.slave (requesters, ALU, response, status, busy)
//
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie.
// Without it, ties go to the requester not granted last (round-robin).

`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module alu_arbiter #(
   parameter int unsigned WORD_WIDTH = `WORD_WIDTH
) (
   input logic          clk,
   input logic          rst,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                state_q, state_d;

   logic [3:0]            op_cmd_q,  op_cmd_d;
   logic [WORD_WIDTH-1:0] op_val1_q, op_val1_d;
   logic [WORD_WIDTH-1:0] op_val2_q, op_val2_d;
   logic                  op_s_q,    op_s_d;
   logic                  op_id_q,   op_id_d;

   logic                  rsp_valid_q, rsp_valid_d;
   logic                  rsp_id_q,    rsp_id_d;
   logic [WORD_WIDTH-1:0] rsp_res_q,   rsp_res_d;
   logic [3:0]            rsp_sr_q,    rsp_sr_d;
   logic [3:0]            status_q,    status_d;

`ifndef ALU_ARB_FIXED_PRIO_EN
   logic                  last_grant_q, last_grant_d;
`endif

   logic                  gnt_en;
   logic                  gnt_id;

   always_comb begin
      state_d     = state_q;
      op_cmd_d    = op_cmd_q;
      op_val1_d   = op_val1_q;
      op_val2_d   = op_val2_q;
      op_s_d      = op_s_q;
      op_id_d     = op_id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_res_d   = rsp_res_q;
      rsp_sr_d    = rsp_sr_q;
      status_d    = status_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = last_grant_q;
`endif
      gnt_en = 1'b0;

      // Winner selection; only meaningful when gnt_en is raised below.
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
         gnt_id = 1'b0;
`else
         gnt_id = ~last_grant_q;
`endif
      end else begin
         gnt_id = bus.req1_valid;
      end

      unique case (state_q)
         IDLE: begin
            // rst gates the grant so no ready is ever seen during reset.
            if ((bus.req0_valid || bus.req1_valid) && !rst) begin
               gnt_en    = 1'b1;
               op_cmd_d  = gnt_id ? bus.req1_cmd  : bus.req0_cmd;
               op_val1_d = gnt_id ? bus.req1_val1 : bus.req0_val1;
               op_val2_d = gnt_id ? bus.req1_val2 : bus.req0_val2;
               op_s_d    = gnt_id ? bus.req1_s    : bus.req0_s;
               op_id_d   = gnt_id;
`ifndef ALU_ARB_FIXED_PRIO_EN
               last_grant_d = gnt_id;
`endif
               state_d   = ISSUE;
            end
         end
         ISSUE: begin
            rsp_res_d   = bus.alu_res;
            rsp_sr_d    = bus.alu_sr;
            rsp_id_d    = op_id_q;
            rsp_valid_d = 1'b1;
            if (op_s_q) begin
               status_d = bus.alu_sr;
            end
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         op_cmd_q    <= '0;
         op_val1_q   <= '0;
         op_val2_q   <= '0;
         op_s_q      <= 1'b0;
         op_id_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_res_q   <= '0;
         rsp_sr_q    <= '0;
         status_q    <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant_q <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         op_cmd_q    <= op_cmd_d;
         op_val1_q   <= op_val1_d;
         op_val2_q   <= op_val2_d;
         op_s_q      <= op_s_d;
         op_id_q     <= op_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_res_q   <= rsp_res_d;
         rsp_sr_q    <= rsp_sr_d;
         status_q    <= status_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign bus.req0_ready = gnt_en & ~gnt_id;
   assign bus.req1_ready = gnt_en &  gnt_id;

   assign bus.alu_val1  = op_val1_q;
   assign bus.alu_val2  = op_val2_q;
   assign bus.alu_cmd   = op_cmd_q;
   assign bus.alu_carry = status_q[2];

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_res   = rsp_res_q;
   assign bus.rsp_sr    = rsp_sr_q;
   assign bus.status    = status_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
